// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults and pixel format, used by the VGA driver
// and the pattern stage feeding it.
package vga_timing_pkg;

  localparam int RGB_W = 12;
  localparam int CNT_W = 10;

  localparam int H_SYNC_DEF  = 96;
  localparam int H_BACK_DEF  = 48;
  localparam int H_DISP_DEF  = 640;
  localparam int H_FRONT_DEF = 16;

  localparam int V_SYNC_DEF  = 2;
  localparam int V_BACK_DEF  = 33;
  localparam int V_DISP_DEF  = 480;
  localparam int V_FRONT_DEF = 10;

endpackage

// File: rtl/vga_driver.sv
// VGA timing generator: free-running h/v counters with combinational decode of
// sync, display enable, pixel request coordinates and frame start.
module vga_driver
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BACK  = H_BACK_DEF,
  parameter int H_DISP  = H_DISP_DEF,
  parameter int H_FRONT = H_FRONT_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BACK  = V_BACK_DEF,
  parameter int V_DISP  = V_DISP_DEF,
  parameter int V_FRONT = V_FRONT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RGB_W-1:0] vga_data,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_de,
  output logic [RGB_W-1:0] vga_rgb,
  output logic [CNT_W-1:0] vga_xpos,
  output logic [CNT_W-1:0] vga_ypos,
  output logic             frame_start
);

  localparam logic [CNT_W-1:0] H_TOTAL = CNT_W'(H_SYNC + H_BACK + H_DISP + H_FRONT);
  localparam logic [CNT_W-1:0] V_TOTAL = CNT_W'(V_SYNC + V_BACK + V_DISP + V_FRONT);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] HA      = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] VA      = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] HA_END  = CNT_W'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CNT_W-1:0] VA_END  = CNT_W'(V_SYNC + V_BACK + V_DISP);
  localparam logic [CNT_W-1:0] REQ_BEG = CNT_W'(H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] REQ_END = CNT_W'(H_SYNC + H_BACK + H_DISP - 1);

  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic             h_last;
  logic             v_active;
  logic             data_req;

  assign h_last = (hcnt == H_TOTAL - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= h_last ? '0 : hcnt + 1'b1;
      if (h_last) begin
        vcnt <= (vcnt == V_TOTAL - 1'b1) ? '0 : vcnt + 1'b1;
      end
    end
  end

  // The request window leads vga_de by one clk so the registered pattern
  // stage returns the pixel exactly when it is displayed.
  always_comb begin
    v_active    = (vcnt >= VA) && (vcnt < VA_END);
    data_req    = (hcnt >= REQ_BEG) && (hcnt < REQ_END) && v_active;
    vga_hs      = (hcnt >= HS_END);
    vga_vs      = (vcnt >= VS_END);
    vga_de      = (hcnt >= HA) && (hcnt < HA_END) && v_active;
    vga_xpos    = data_req ? hcnt - REQ_BEG : '0;
    vga_ypos    = data_req ? vcnt - VA : '0;
    frame_start = (hcnt == '0) && (vcnt == '0);
    vga_rgb     = vga_de ? vga_data : '0;
  end

endmodule

// File: tb/tb_vga_driver.sv
// Bench for vga_driver with reduced timing: fixed vector table, randomized
// pixel data against a frame-position model, and a mid-frame reset sequence.
module tb_vga_driver;

  localparam int HS = 8, HB = 6, HD = 20, HF = 4;
  localparam int VS = 2, VB = 3, VD = 10, VF = 2;
  localparam int HT = HS + HB + HD + HF;
  localparam int VT = VS + VB + VD + VF;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] rgb;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        fs;
  } exp_t;

  typedef struct {
    int          t;
    logic [11:0] data;
    exp_t        exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [11:0] vga_data;
  logic        vga_hs, vga_vs, vga_de, frame_start;
  logic [11:0] vga_rgb;
  logic [9:0]  vga_xpos, vga_ypos;

  int n_cmp;
  int n_bad;
  int t;

  vga_driver #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vga_data(vga_data),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de), .vga_rgb(vga_rgb),
    .vga_xpos(vga_xpos), .vga_ypos(vga_ypos), .frame_start(frame_start)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Position in the frame follows from elapsed clks since release alone.
  function automatic exp_t model(int tick, logic [11:0] data);
    exp_t e;
    int h, v, ha, va;
    h  = tick % HT;
    v  = (tick / HT) % VT;
    ha = HS + HB;
    va = VS + VB;
    e.hs  = (h >= HS);
    e.vs  = (v >= VS);
    e.de  = (h >= ha) && (h < ha + HD) && (v >= va) && (v < va + VD);
    e.rgb = e.de ? data : 12'h000;
    if ((h >= ha - 1) && (h < ha + HD - 1) && (v >= va) && (v < va + VD)) begin
      e.x = 10'(h - (ha - 1));
      e.y = 10'(v - va);
    end else begin
      e.x = '0;
      e.y = '0;
    end
    e.fs = (h == 0) && (v == 0);
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e = '0;
    e.fs = 1'b1;
    return e;
  endfunction

  task automatic check(input string name, input exp_t e);
    exp_t a;
    a = '{vga_hs, vga_vs, vga_de, vga_rgb, vga_xpos, vga_ypos, frame_start};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s t=%0d: got hs=%b vs=%b de=%b rgb=%h x=%0d y=%0d fs=%b, want hs=%b vs=%b de=%b rgb=%h x=%0d y=%0d fs=%b",
               name, t, a.hs, a.vs, a.de, a.rgb, a.x, a.y, a.fs,
               e.hs, e.vs, e.de, e.rgb, e.x, e.y, e.fs);
    end
  endtask

  // driver: one active edge, then settle away from the edge
  task automatic step();
    @(posedge clk);
    #2;
    t++;
  endtask

  vec_t vecs[15];

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    t        = 0;
    rst_n    = 1'b0;
    vga_data = 12'hFFF;

    // Hand-derived for HT=38 (HA=14), VT=17 (VA=5). Fields: hs vs de rgb x y fs
    vecs[0]  = '{0,   12'hF00, '{1'b0, 1'b0, 1'b0, 12'h000, 10'd0,  10'd0, 1'b1}};
    vecs[1]  = '{7,   12'hF00, '{1'b0, 1'b0, 1'b0, 12'h000, 10'd0,  10'd0, 1'b0}};
    vecs[2]  = '{8,   12'hF00, '{1'b1, 1'b0, 1'b0, 12'h000, 10'd0,  10'd0, 1'b0}};
    vecs[3]  = '{37,  12'hF00, '{1'b1, 1'b0, 1'b0, 12'h000, 10'd0,  10'd0, 1'b0}};
    vecs[4]  = '{38,  12'hF00, '{1'b0, 1'b0, 1'b0, 12'h000, 10'd0,  10'd0, 1'b0}};
    vecs[5]  = '{76,  12'hF00, '{1'b0, 1'b1, 1'b0, 12'h000, 10'd0,  10'd0, 1'b0}};
    vecs[6]  = '{166, 12'hF00, '{1'b1, 1'b1, 1'b0, 12'h000, 10'd0,  10'd0, 1'b0}};
    vecs[7]  = '{203, 12'hF00, '{1'b1, 1'b1, 1'b0, 12'h000, 10'd0,  10'd0, 1'b0}};
    vecs[8]  = '{204, 12'hF00, '{1'b1, 1'b1, 1'b1, 12'hF00, 10'd1,  10'd0, 1'b0}};
    vecs[9]  = '{222, 12'h0A5, '{1'b1, 1'b1, 1'b1, 12'h0A5, 10'd19, 10'd0, 1'b0}};
    vecs[10] = '{223, 12'h123, '{1'b1, 1'b1, 1'b1, 12'h123, 10'd0,  10'd0, 1'b0}};
    vecs[11] = '{224, 12'hF00, '{1'b1, 1'b1, 1'b0, 12'h000, 10'd0,  10'd0, 1'b0}};
    vecs[12] = '{552, 12'h0FF, '{1'b1, 1'b1, 1'b1, 12'h0FF, 10'd7,  10'd9, 1'b0}};
    vecs[13] = '{584, 12'hF00, '{1'b1, 1'b1, 1'b0, 12'h000, 10'd0,  10'd0, 1'b0}};
    vecs[14] = '{646, 12'hF00, '{1'b0, 1'b0, 1'b0, 12'h000, 10'd0,  10'd0, 1'b1}};

    repeat (3) @(posedge clk);
    #2;
    check("in_reset", reset_exp());
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    #1;

    // table-driven vectors
    for (int i = 0; i < 15; i++) begin
      while (t < vecs[i].t) step();
      vga_data = vecs[i].data;
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // randomized pixel data over two frames
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      vga_data = 12'($urandom_range(0, 4095));
      #1;
      check("rand", model(t, vga_data));
    end

    // mid-frame reset at line 8, pixel 20
    while ((t % FRAME) != 8 * HT + 20) step();
    vga_data = 12'hABC;
    #1;
    check("pre_reset", model(t, vga_data));
    rst_n = 1'b0;
    #1;
    check("reset_assert", reset_exp());
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      vga_data = 12'($urandom_range(1, 4095));
      #1;
      check("reset_hold", reset_exp());
    end
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    #1;
    check("restart", model(t, vga_data));
    for (int i = 0; i < HT + 10; i++) begin
      step();
      vga_data = 12'($urandom_range(0, 4095));
      #1;
      check("after_reset", model(t, vga_data));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
